// File: rtl/cop0_info.sv
// Shared CP0 types for the exception scheduler: CP0 register layouts, scheduler
// state and request kinds, exception vector constants and the vector helper.
package cop0_info;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } sched_state_e;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_EXC  = 2'd1,
        KIND_ERET = 2'd2,
        KIND_INT  = 2'd3
    } exc_kind_e;

    localparam logic [4:0]  EXC_INT      = 5'd0;
    localparam logic [31:0] VEC_BEV_BASE = 32'hBFC0_0200;
    localparam logic [31:0] VEC_OFS_GEN  = 32'h0000_0180;
    localparam logic [31:0] VEC_OFS_INT  = 32'h0000_0200;

    typedef struct packed {
        logic [3:0] cu;
        logic [4:0] rsv_27_23;
        logic       bev;
        logic [5:0] rsv_21_16;
        logic [7:0] im;
        logic [4:0] rsv_7_3;
        logic       erl;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic       bd;
        logic       ti;
        logic [1:0] ce;
        logic [3:0] rsv_27_24;
        logic       iv;
        logic [6:0] rsv_22_16;
        logic [7:0] ip;
        logic       rsv_7;
        logic [4:0] exc_code;
        logic [1:0] rsv_1_0;
    } cause_t;

    typedef struct packed {
        logic        one;
        logic        zero;
        logic [17:0] base;
        logic [1:0]  rsv_11_10;
        logic [9:0]  cpunum;
    } ebase_t;

    // Interrupts only use the dedicated 0x200 offset when Cause.IV is set.
    function automatic logic [31:0] exc_vector(input logic        bev,
                                               input logic        iv,
                                               input logic [19:0] ebase_hi,
                                               input logic        is_int);
        logic [31:0] base;
        base = bev ? VEC_BEV_BASE : {ebase_hi, 12'h000};
        return base + ((is_int && iv) ? VEC_OFS_INT : VEC_OFS_GEN);
    endfunction

endpackage

// File: rtl/cop0_timer.sv
// CP0 Count/Compare timer: Count advances once every COUNT_DIV clocks and
// Cause.TI is raised when an increment lands on Compare.
module cop0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we,
    input  logic [31:0] count_wdata,
    input  logic        compare_we,
    input  logic [31:0] compare_wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

    logic [DW-1:0] div_q;
    logic [31:0]   count_q;
    logic [31:0]   compare_q;
    logic [31:0]   count_inc;
    logic          ti_q;
    logic          tick;

    assign tick      = (div_q == DIV_LAST);
    assign count_inc = count_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            // A software write to Count replaces the increment in that cycle.
            if (count_we) begin
                count_q <= count_wdata;
            end else if (tick) begin
                count_q <= count_inc;
            end
            if (compare_we) begin
                compare_q <= compare_wdata;
            end
            if (compare_we) begin
                ti_q <= 1'b0;
            end else if (tick && !count_we && (count_inc == compare_q)) begin
                ti_q <= 1'b1;
            end
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cop0_exc_sched.sv
// MIPS CP0 exception/ERET scheduler: arbitrate, flush, commit, redirect.
// Define COP0_TIMER_EN to build in the Count/Compare timer (cop0_timer).
module cop0_exc_sched #(
    parameter int COUNT_DIV  = 2,
    parameter int NUM_HW_INT = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_epc,
    input  logic                  exc_in_bd,
    input  logic                  exc_load_addr,
    input  logic [31:0]           exc_badvaddr,
    output logic                  exc_ack,
    input  logic                  eret_valid,
    input  logic [31:0]           int_epc,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic [31:0]           status_i,
    input  logic [31:0]           cause_i,
    input  logic [31:0]           ebase_i,
    input  logic [31:0]           epc_i,
    input  logic [31:0]           errorepc_i,
    output logic                  flush,
    output logic                  cm_valid,
    output logic                  cm_kind,
    output logic [4:0]            cm_exc_code,
    output logic                  cm_in_bd,
    output logic                  cm_epc_we,
    output logic [31:0]           cm_epc,
    output logic                  cm_bva_we,
    output logic [31:0]           cm_badvaddr,
    output logic                  cm_clr_erl,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [31:0]           redirect_pc,
    output logic [7:0]            ip_o,
    input  logic                  count_we,
    input  logic [31:0]           count_wdata,
    input  logic                  compare_we,
    input  logic [31:0]           compare_wdata,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic                  ti_o,
    output logic [1:0]            dbg_state
);

    import cop0_info::*;

    // Handshakes: exc_valid/eret_valid are held by the pipeline until exc_ack,
    // which pulses only in the IDLE cycle that latches the request; redirect_valid
    // and redirect_pc hold steady until the cycle redirect_ready is also high.

    status_t             st;
    cause_t              ca;
    ebase_t              eb;
    sched_state_e        state_q;
    sched_state_e        state_d;
    exc_kind_e           win_kind;
    exc_kind_e           kind_q;
    logic                accept;
    logic                int_pending;
    logic                ti;
    logic                commit;
    logic [NUM_HW_INT+5:0] hw_pad;
    logic [5:0]          hw6;
    logic                unused_cfg;

    logic [4:0]          code_q;
    logic [31:0]         epc_q;
    logic [31:0]         bva_q;
    logic [31:0]         pc_q;
    logic                bd_q;
    logic                epc_we_q;
    logic                bva_we_q;
    logic                clr_erl_q;

    assign st = status_t'(status_i);
    assign ca = cause_t'(cause_i);
    assign eb = ebase_t'(ebase_i);

    // Lines beyond NUM_HW_INT read as 0 so IP[7:2] is always six bits wide.
    assign hw_pad = {6'b000000, hw_int};
    assign hw6    = hw_pad[5:0];
    assign ip_o   = {hw6[5] | ti, hw6[4:0], ca.ip[1:0]};

    assign int_pending = st.ie && !st.exl && !st.erl && ((ip_o & st.im) != 8'h00);

    always_comb begin
        win_kind = KIND_NONE;
        if (exc_valid) begin
            win_kind = KIND_EXC;
        end else if (eret_valid) begin
            win_kind = KIND_ERET;
        end else if (int_pending) begin
            win_kind = KIND_INT;
        end
    end

    assign accept = (state_q == ST_IDLE) && (win_kind != KIND_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        exc_ack        = 1'b0;
        flush          = 1'b0;
        cm_valid       = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_FLUSH;
                    exc_ack = (win_kind == KIND_EXC) || (win_kind == KIND_ERET);
                end
            end
            ST_FLUSH: begin
                flush   = 1'b1;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                cm_valid = 1'b1;
                state_d  = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Everything the commit and redirect need is captured at acceptance, so
    // later changes to Status/EPC/request inputs cannot disturb the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q    <= KIND_NONE;
            code_q    <= '0;
            epc_q     <= '0;
            bva_q     <= '0;
            pc_q      <= '0;
            bd_q      <= 1'b0;
            epc_we_q  <= 1'b0;
            bva_we_q  <= 1'b0;
            clr_erl_q <= 1'b0;
        end else if (accept) begin
            kind_q    <= win_kind;
            code_q    <= (win_kind == KIND_EXC) ? exc_code : EXC_INT;
            bva_q     <= exc_badvaddr;
            bd_q      <= (win_kind == KIND_EXC) && exc_in_bd;
            epc_we_q  <= (win_kind != KIND_ERET) && !st.exl;
            bva_we_q  <= (win_kind == KIND_EXC) && exc_load_addr;
            clr_erl_q <= (win_kind == KIND_ERET) && st.erl;
            case (win_kind)
                KIND_EXC:  epc_q <= exc_epc;
                KIND_INT:  epc_q <= int_epc;
                default:   epc_q <= 32'd0;
            endcase
            if (win_kind == KIND_ERET) begin
                pc_q <= st.erl ? errorepc_i : epc_i;
            end else begin
                pc_q <= exc_vector(st.bev, ca.iv, {eb.one, eb.zero, eb.base},
                                   win_kind == KIND_INT);
            end
        end
    end

    assign commit      = (state_q == ST_COMMIT);
    assign cm_kind     = commit && (kind_q == KIND_ERET);
    assign cm_exc_code = commit ? code_q : 5'd0;
    assign cm_in_bd    = commit && bd_q;
    assign cm_epc_we   = commit && epc_we_q;
    assign cm_epc      = commit ? epc_q : 32'd0;
    assign cm_bva_we   = commit && bva_we_q;
    assign cm_badvaddr = commit ? bva_q : 32'd0;
    assign cm_clr_erl  = commit && clr_erl_q;
    assign redirect_pc = redirect_valid ? pc_q : 32'd0;
    assign dbg_state   = state_q;

`ifdef COP0_TIMER_EN
    cop0_timer #(
        .COUNT_DIV(COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_we     (count_we),
        .count_wdata  (count_wdata),
        .compare_we   (compare_we),
        .compare_wdata(compare_wdata),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .ti_o         (ti)
    );
    assign unused_cfg = ^{status_i, cause_i, ebase_i[11:0], hw_pad};
`else
    assign count_o   = 32'd0;
    assign compare_o = 32'd0;
    assign ti        = 1'b0;
    assign unused_cfg = ^{status_i, cause_i, ebase_i[11:0], hw_pad, count_we,
                          count_wdata, compare_we, compare_wdata, COUNT_DIV[0]};
`endif

    assign ti_o = ti;

endmodule
